// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : gray_pkg
//  Purpose : Shared constants and Gray/binary conversion helpers for the
//            gray_counter_n family.
//  Contents: MAX_WIDTH      - widest vector the helpers operate on
//            WRAP_MODE/SAT_MODE - encodings of the WRAP parameter
//            max_val()      - all-ones value for a given width
//            bin2gray()     - g = b ^ (b >> 1)
//            gray2bin()     - inverse prefix-XOR
//  Revision: 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int MAX_WIDTH = 32;

  localparam int WRAP_MODE = 1;
  localparam int SAT_MODE  = 0;

  // Helpers work on a MAX_WIDTH vector. A narrower value is zero-extended,
  // and zero upper bits convert to zero upper bits in either direction.
  // Callers therefore truncate the result back to their own WIDTH.
  function automatic logic [MAX_WIDTH-1:0] max_val(input int width);
    logic [MAX_WIDTH-1:0] one;
    one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    if (width >= MAX_WIDTH) return '1;
    return (one << width) - one;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2gray_n.sv
`default_nettype none
// ============================================================================
//  Module  : bin2gray_n
//  Purpose : Combinational WIDTH-bit binary to Gray-code converter.
//  Ports   : bin  (in,  WIDTH) - binary value
//            gray (out, WIDTH) - bin ^ (bin >> 1)
//  Revision: 1.0 - initial release
// ============================================================================
module bin2gray_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// ============================================================================
//  Module  : gray_counter_n
//  Purpose : Parametrised up/down Gray-code counter with binary mirror,
//            synchronous load, wrap or saturate at the boundaries, sticky
//            overflow flag and a terminal-count strobe.
//  Ports   : Clk      (in)         rising-edge clock
//            Reset    (in)         asynchronous active-low reset
//            En       (in)         count enable, one step per clock
//            Up       (in)         1 = increment, 0 = decrement
//            Load     (in)         synchronous load of LoadVal, beats En
//            LoadVal  (in, WIDTH)  binary load value
//            OvClr    (in)         synchronous clear of Overflow
//            Output   (out, WIDTH) registered Gray count
//            BinOut   (out, WIDTH) registered binary count
//            Overflow (out)        sticky boundary-crossing flag
//            Tc       (out)        combinational terminal count
//  Revision: 1.0 - initial release
// ============================================================================
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int WRAP      = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             OvClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] c_max        = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] c_reset_bin  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_reset_gray = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VAL)));
  localparam bit               c_wrap       = (WRAP == WRAP_MODE);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_ov;

  logic             w_step;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_ov_next;

  // Boundary is direction dependent: MAX when counting up, 0 when down.
  assign w_at_bound = Up ? (r_bin == c_max) : (r_bin == '0);
  assign w_step     = En & ~Load;
  assign Tc         = w_step & w_at_bound;

  always_comb begin
    w_bin_next = r_bin;
    if (Load) begin
      w_bin_next = LoadVal;
    end else if (En) begin
      if (w_at_bound) begin
        // Plain +1/-1 already wraps modulo 2^WIDTH; saturation holds.
        if (c_wrap) begin
          w_bin_next = Up ? (r_bin + 1'b1) : (r_bin - 1'b1);
        end
      end else begin
        w_bin_next = Up ? (r_bin + 1'b1) : (r_bin - 1'b1);
      end
    end
  end

  // Set beats clear when a boundary event and OvClr share an edge.
  always_comb begin
    w_ov_next = r_ov;
    if (Tc) begin
      w_ov_next = 1'b1;
    end else if (OvClr) begin
      w_ov_next = 1'b0;
    end
  end

  // Gray register is fed from the converted next-state binary so both
  // outputs update on the same edge and never disagree.
  bin2gray_n #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (w_bin_next),
    .gray (w_gray_next)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_bin  <= c_reset_bin;
      r_gray <= c_reset_gray;
      r_ov   <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_ov   <= w_ov_next;
    end
  end

  assign BinOut   = r_bin;
  assign Output   = r_gray;
  assign Overflow = r_ov;

endmodule
`default_nettype wire

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
Parametrised Gray-code counter, the successor to the fixed 3-bit gray counter. It adds configurable width, up/down counting, synchronous binary load, a wrap or saturate mode, a sticky overflow flag with clear, and a terminal-count strobe. It sits beside the pipeline as a glitch-free event/pointer counter, e.g. for clock-domain-safe pointers and cycle counters. The Gray output and the binary mirror are both registered and always consistent.

Parameters:
WIDTH, 3, counter width in bits (>=2).
WRAP, 1, 1 = wrap at the boundary, 0 = saturate at the boundary.
RESET_VAL, 0, binary value loaded on reset (must be < 2^WIDTH).

Ports:
Clk  input  1  single clock, rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
En  input  1  count enable; one step per Clk while high.
Up  input  1  direction: 1 = increment, 0 = decrement.
Load  input  1  synchronous load of LoadVal; has priority over En.
LoadVal  input  WIDTH  binary value to load.
OvClr  input  1  synchronous clear of Overflow.
Output  output  WIDTH  registered Gray-code count.
BinOut  output  WIDTH  registered binary count (Output == bin2gray(BinOut) at all times).
Overflow  output  1  sticky flag: a boundary crossing or attempted crossing occurred.
Tc  output  1  combinational terminal count: En & ~Load & at boundary in the current direction.

Behaviour:
- Reset low, asynchronous: BinOut=RESET_VAL, Output=bin2gray(RESET_VAL), Overflow=0. Release is sampled on the first rising Clk edge with Reset high.
- Latency: every update appears 1 Clk after the qualifying inputs are sampled. No combinational path from inputs to Output or BinOut.
- Priority per edge: Load > En. With Load=1, BinOut<=LoadVal and Output<=bin2gray(LoadVal), regardless of En and Up. Load never sets Overflow.
- En=0 and Load=0: hold.
- En=1, Up=1, BinOut<MAX (MAX=2^WIDTH-1): BinOut+1.
- En=1, Up=0, BinOut>0: BinOut-1.
- Boundary, Up=1 at MAX or Up=0 at 0:
  - WRAP=1: wrap to 0 or MAX respectively.
  - WRAP=0: hold.
  - Either mode: Overflow<=1.
- Gray property: every En step, including the wrap step, changes exactly one bit of Output. Saturate-hold changes no bits. Load may change any number of bits.
- Overflow is sticky until OvClr=1. If OvClr and a boundary event occur on the same edge, set wins (Overflow=1).
- Tc is high in the cycle before a boundary step. It is low during Load, whatever the value.
- Up may change on any cycle. It takes effect on that edge, with no extra latency.
- Reset mid-count: immediate return to the reset values. Any pending Load or En is discarded.
- Arithmetic is WIDTH-bit unsigned. Gray conversion: g = b ^ (b>>1).

Decomposition:
- Shared package/header gray_pkg holds:
  - bin2gray and gray2bin functions, parameterised on WIDTH;
  - localparam-style constants for MAX and the WRAP mode encodings.
- One natural combinational sub-module, bin2gray_n (parameter WIDTH), instantiated on the next-state binary value. The Gray register is loaded from it, so Output and BinOut update on the same edge.
- Counter control (priority, boundary detect, Overflow, Tc) stays in gray_counter_n.

Test Plan:
- WIDTH=3, WRAP=1, Up=1, En=1 for 9 edges after reset -> Output 000,001,011,010,110,111,101,100,000. Overflow=1 after the 100->000 step. Tc=1 only while Output=100. Check exactly one bit flips per step.
- WIDTH=3, WRAP=1, Up=0 from reset (0) -> BinOut 7 (Output 100) after one edge, Overflow=1. Assert OvClr one cycle -> Overflow=0, and it stays 0 while counting down 7..1.
- WIDTH=3, WRAP=0, Load LoadVal=6, then En=1, Up=1 for 3 edges -> BinOut 7 then holds at 7, Output holds 100, Overflow=1. Down-count from 0 holds at 0 and sets Overflow.
- Load=1 with En=1, LoadVal=5 at BinOut=7, WRAP=1 -> BinOut=5, Output=111, Overflow unchanged, Tc=0 in that cycle.
- OvClr=1 on the same edge as the 7->0 wrap -> Overflow=1 after the edge.
- Reset pulled low asynchronously mid-cycle at count 4, RESET_VAL=2 -> BinOut=2 and Output=011 immediately, without waiting for Clk. Counting resumes from 2 on the first edge after release.
